uart_program_loader: RTL and testbench
======================================

// Module: uart_program_loader
// PURPOSE
// - Multi-region successor to the single-image UART programmer: takes a deserialised
//   UART byte stream and writes framed images into NUM_REGIONS memory write ports.
// - Targets are instruction memory, data memory and any further regions.
// - Holds the CPU while loading. Validates region, length and checksum. Ends the session
//   on an end marker or an idle timeout. Reports errors. One clock domain.
// PARAMETERS
// - NUM_REGIONS     2            number of target memories (1..8)
// - REGION_ADDR_W   14           word-address width of each region
// - DATA_W          32           word width; multiple of 8; BPW = DATA_W/8
// - TIMEOUT_CYCLES  100_000_000  idle cycles (between accepted bytes) that end a session
// PORTS
// - iFpgaClock      in   1              system clock, all logic on posedge
// - iFpgaResetN     in   1              asynchronous active-low reset
// - iStartLoad      in   1              single-cycle start pulse from the debounced button
// - iRxValid        in   1              one-cycle strobe: iRxByte holds a received byte
// - iRxByte         in   8              received UART byte
// - oWriteEnable    out  NUM_REGIONS    one-hot write strobe to the selected region
// - oWriteAddress   out  REGION_ADDR_W  word address within the region
// - oWriteData      out  DATA_W         assembled word
// - oCpuHold        out  1              1 = keep CPU in reset
// - oLoadDone       out  1              session completed cleanly (level)
// - oError          out  1              session aborted (level)
// - oErrorCode      out  3              cause of abort, see below
// - oWordCount      out  16             words written this session, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset:
//   - State IDLE.
//   - All outputs 0, including oWriteEnable, oCpuHold, oLoadDone, oError, oErrorCode,
//     oWordCount, address and data.
// - Frame format: 0xA5, region, lenLo, lenHi, len*BPW data bytes, csum.
//   - Data words are little-endian; the first byte is bits [7:0].
//   - csum is the XOR of all data bytes in the frame.
//   - In place of a header, 0x5A ends the session.
// - States and transitions:
//   - IDLE: on iStartLoad -> WAIT_HDR.
//   - WAIT_HDR: 0xA5 -> GET_REGION. 0x5A -> DONE. Any other byte -> ERROR, code 5.
//   - GET_REGION: index >= NUM_REGIONS -> ERROR, code 1. Otherwise latch it -> GET_LEN_LO.
//   - GET_LEN_LO -> GET_LEN_HI.
//   - GET_LEN_HI: len == 0 or len > 2**REGION_ADDR_W -> ERROR, code 2.
//     Otherwise clear the word index and the XOR accumulator -> GET_DATA.
//   - GET_DATA: shift bytes into the word. After byte BPW, register a write (see below).
//     After the last word -> GET_CSUM.
//   - GET_CSUM: match -> WAIT_HDR and count one completed frame. Mismatch -> ERROR, code 3.
//   - DONE and ERROR: hold until iStartLoad or reset.
// - Write timing:
//   - The cycle after the strobe of a word's last byte, oWriteEnable[region] = 1 for
//     exactly one cycle.
//   - oWriteAddress and oWriteData are stable during that cycle.
//   - The word index then increments.
//   - oWordCount increments in the same cycle as the strobe.
// - oCpuHold:
//   - 1 in every state except IDLE and DONE.
//   - Stays 1 in ERROR so a corrupt image never runs.
// - Timeout counter:
//   - Cleared by each accepted byte and on entry to WAIT_HDR. Counts only in WAIT_HDR
//     through GET_CSUM.
//   - On reaching TIMEOUT_CYCLES in WAIT_HDR with at least one frame completed -> DONE.
//   - On reaching it in WAIT_HDR with zero frames: no effect, keep waiting.
//   - On reaching it in any other state -> ERROR, code 4.
// - iStartLoad in any state:
//   - Restart to WAIT_HDR.
//   - Clear oLoadDone, oError, oErrorCode, oWordCount, the frame count and the timeout.
//   - iStartLoad wins over a simultaneous iRxValid; that byte is dropped.
// - Bytes outside a session: iRxValid is ignored in IDLE, DONE and ERROR.
// - Words already written before a checksum or timeout error are not rolled back.
// - Async reset mid-frame: immediate return to IDLE. A pending write strobe is cancelled.
// - oErrorCode holds its value while in ERROR; it is 0 otherwise.
// TESTING
// - Reset, then 0xA5, 0x00, 0x02, 0x00, bytes 11 22 33 44 55 66 77 88, csum 0x88, 0x5A
//   -> two writes to region 0:
//   - addr 0, data 0x44332211.
//   - addr 1, data 0x88776655.
//   - Then oLoadDone=1, oCpuHold=0, oWordCount=2.
// - Two frames, region 0 len 1 then region 1 len 1, then idle for TIMEOUT_CYCLES
//   -> one strobe on each of oWriteEnable[0] and oWriteEnable[1], then DONE.
// - Region byte 0x02 with NUM_REGIONS=2 -> oError=1, code 1, oCpuHold stays 1, no strobes.
// - Frame with a wrong csum -> ERROR, code 3.
//   - Then iStartLoad -> error cleared, WAIT_HDR, oWordCount=0.
// - Idle mid-GET_DATA for TIMEOUT_CYCLES -> ERROR, code 4.
//   - iStartLoad in the same cycle as iRxValid -> byte dropped, state WAIT_HDR.
// - Assert iFpgaResetN=0 during a GET_DATA word -> all outputs 0 immediately.
//   - Then a full len=2**REGION_ADDR_W frame -> last write at addr 2**REGION_ADDR_W-1.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// Byte-stream, memory-write and status bundle between a UART front end and the program loader.
interface uart_program_loader_if #(
  parameter int NUM_REGIONS   = 2,
  parameter int REGION_ADDR_W = 14,
  parameter int DATA_W        = 32
);
  logic                     iStartLoad;
  logic                     iRxValid;
  logic [7:0]               iRxByte;
  logic [NUM_REGIONS-1:0]   oWriteEnable;
  logic [REGION_ADDR_W-1:0] oWriteAddress;
  logic [DATA_W-1:0]        oWriteData;
  logic                     oCpuHold;
  logic                     oLoadDone;
  logic                     oError;
  logic [2:0]               oErrorCode;
  logic [15:0]              oWordCount;

  modport master (
    output iStartLoad, iRxValid, iRxByte,
    input  oWriteEnable, oWriteAddress, oWriteData, oCpuHold,
    input  oLoadDone, oError, oErrorCode, oWordCount
  );

  modport slave (
    input  iStartLoad, iRxValid, iRxByte,
    output oWriteEnable, oWriteAddress, oWriteData, oCpuHold,
    output oLoadDone, oError, oErrorCode, oWordCount
  );
endinterface

// File: rtl/uart_program_loader.sv
// Frames a UART byte stream into words and writes them to one of NUM_REGIONS memories,
// holding the CPU in reset while a session is active or has failed.
module uart_program_loader #(
  parameter int NUM_REGIONS    = 2,
  parameter int REGION_ADDR_W  = 14,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input logic            iFpgaClock,
  input logic            iFpgaResetN,
  uart_program_loader_if.slave bus
);
  localparam int BPW = DATA_W / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [16:0] MAX_LEN = 17'(64'd1 << REGION_ADDR_W);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] WAIT_HDR   = 4'd1;
  localparam logic [3:0] GET_REGION = 4'd2;
  localparam logic [3:0] GET_LEN_LO = 4'd3;
  localparam logic [3:0] GET_LEN_HI = 4'd4;
  localparam logic [3:0] GET_DATA   = 4'd5;
  localparam logic [3:0] GET_CSUM   = 4'd6;
  localparam logic [3:0] DONE       = 4'd7;
  localparam logic [3:0] ERROR      = 4'd8;

  logic [3:0]               state_r;
  logic [2:0]               region_r;
  logic [7:0]               len_lo_r;
  logic [16:0]              len_r;
  logic [16:0]              word_idx_r;
  logic [BIW-1:0]           byte_idx_r;
  logic [DATA_W-1:0]        shift_r;
  logic [7:0]               csum_r;
  logic [TW-1:0]            timeout_r;
  logic                     frame_seen_r;
  logic [NUM_REGIONS-1:0]   we_r;
  logic [REGION_ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0]        data_r;
  logic                     hold_r;
  logic                     done_r;
  logic                     err_r;
  logic [2:0]               code_r;
  logic [15:0]              wc_r;
  logic [DATA_W-1:0]        word_next_s;
  logic [16:0]              len_in_s;

  // Little-endian assembly: each new byte enters at the top and earlier bytes slide down.
  assign word_next_s = (shift_r >> 8) | (DATA_W'(bus.iRxByte) << (DATA_W - 8));
  assign len_in_s    = {1'b0, bus.iRxByte, len_lo_r};

  // Session FSM, word assembly, write strobe and status registers.
  always_ff @(posedge iFpgaClock or negedge iFpgaResetN) begin
    if (!iFpgaResetN) begin
      state_r      <= IDLE;
      region_r     <= 3'd0;
      len_lo_r     <= 8'd0;
      len_r        <= 17'd0;
      word_idx_r   <= 17'd0;
      byte_idx_r   <= '0;
      shift_r      <= '0;
      csum_r       <= 8'd0;
      timeout_r    <= '0;
      frame_seen_r <= 1'b0;
      we_r         <= '0;
      addr_r       <= '0;
      data_r       <= '0;
      hold_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      code_r       <= 3'd0;
      wc_r         <= 16'd0;
    end else begin
      we_r <= '0;
      if (bus.iStartLoad) begin
        state_r      <= WAIT_HDR;
        hold_r       <= 1'b1;
        done_r       <= 1'b0;
        err_r        <= 1'b0;
        code_r       <= 3'd0;
        wc_r         <= 16'd0;
        frame_seen_r <= 1'b0;
        timeout_r    <= '0;
      end else begin
        case (state_r)
          IDLE, DONE, ERROR: begin
          end
          default: begin
            if (bus.iRxValid) begin
              timeout_r <= '0;
              case (state_r)
                WAIT_HDR: begin
                  if (bus.iRxByte == 8'hA5) begin
                    state_r <= GET_REGION;
                  end else if (bus.iRxByte == 8'h5A) begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                    hold_r  <= 1'b0;
                  end else begin
                    state_r <= ERROR;
                    err_r   <= 1'b1;
                    code_r  <= 3'd5;
                  end
                end
                GET_REGION: begin
                  if (bus.iRxByte >= 8'(NUM_REGIONS)) begin
                    state_r <= ERROR;
                    err_r   <= 1'b1;
                    code_r  <= 3'd1;
                  end else begin
                    region_r <= bus.iRxByte[2:0];
                    state_r  <= GET_LEN_LO;
                  end
                end
                GET_LEN_LO: begin
                  len_lo_r <= bus.iRxByte;
                  state_r  <= GET_LEN_HI;
                end
                GET_LEN_HI: begin
                  if ((len_in_s == 17'd0) || (len_in_s > MAX_LEN)) begin
                    state_r <= ERROR;
                    err_r   <= 1'b1;
                    code_r  <= 3'd2;
                  end else begin
                    len_r      <= len_in_s;
                    word_idx_r <= 17'd0;
                    byte_idx_r <= '0;
                    csum_r     <= 8'd0;
                    state_r    <= GET_DATA;
                  end
                end
                GET_DATA: begin
                  shift_r <= word_next_s;
                  csum_r  <= csum_r ^ bus.iRxByte;
                  if (byte_idx_r == BIW'(BPW - 1)) begin
                    byte_idx_r <= '0;
                    we_r       <= NUM_REGIONS'(1) << region_r;
                    addr_r     <= word_idx_r[REGION_ADDR_W-1:0];
                    data_r     <= word_next_s;
                    word_idx_r <= word_idx_r + 17'd1;
                    if (wc_r != 16'hFFFF) begin
                      wc_r <= wc_r + 16'd1;
                    end
                    if (word_idx_r == len_r - 17'd1) begin
                      state_r <= GET_CSUM;
                    end
                  end else begin
                    byte_idx_r <= byte_idx_r + BIW'(1);
                  end
                end
                GET_CSUM: begin
                  if (bus.iRxByte == csum_r) begin
                    frame_seen_r <= 1'b1;
                    state_r      <= WAIT_HDR;
                  end else begin
                    state_r <= ERROR;
                    err_r   <= 1'b1;
                    code_r  <= 3'd3;
                  end
                end
                default: begin
                  state_r <= IDLE;
                end
              endcase
            end else if (timeout_r == TW'(TIMEOUT_CYCLES - 1)) begin
              // An idle header wait only ends the session once something was loaded.
              timeout_r <= '0;
              if (state_r == WAIT_HDR) begin
                if (frame_seen_r) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  hold_r  <= 1'b0;
                end
              end else begin
                state_r <= ERROR;
                err_r   <= 1'b1;
                code_r  <= 3'd4;
              end
            end else begin
              timeout_r <= timeout_r + TW'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.oWriteEnable  = we_r;
  assign bus.oWriteAddress = addr_r;
  assign bus.oWriteData    = data_r;
  assign bus.oCpuHold      = hold_r;
  assign bus.oLoadDone     = done_r;
  assign bus.oError        = err_r;
  assign bus.oErrorCode    = code_r;
  assign bus.oWordCount    = wc_r;
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench: expected writes go into a scoreboard queue, a negedge monitor pops them.
module tb_uart_program_loader;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 40;

  typedef struct packed {
    logic [NR-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  uart_program_loader_if #(.NUM_REGIONS(NR), .REGION_ADDR_W(AW), .DATA_W(DW)) bus ();

  uart_program_loader #(
    .NUM_REGIONS(NR), .REGION_ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iFpgaClock (clk),
    .iFpgaResetN(rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.oWriteEnable != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got we=%b addr=%0h data=%0h expected none",
                 bus.oWriteEnable, bus.oWriteAddress, bus.oWriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write", 64'({bus.oWriteEnable, bus.oWriteAddress, bus.oWriteData}), 64'(e));
      end
    end
  end

  task automatic push(input int region, input int addr, input logic [31:0] data);
    wr_t e;
    e.we   = NR'(1) << region;
    e.addr = AW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.iRxValid = 1'b1;
    bus.iRxByte  = b;
    @(posedge clk);
    #1;
    bus.iRxValid = 1'b0;
  endtask

  task automatic start_load();
    bus.iStartLoad = 1'b1;
    @(posedge clk);
    #1;
    bus.iStartLoad = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic [7:0] region, input logic [15:0] len);
    send_byte(8'hA5);
    send_byte(region);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  // Sends nwords*4 bytes seed, seed+step, ... then their XOR with csum_flip applied.
  task automatic send_data(input int nwords, input logic [7:0] seed, input logic [7:0] step,
                           input logic [7:0] csum_flip);
    logic [7:0] b;
    logic [7:0] cs;
    b  = seed;
    cs = 8'h00;
    for (int i = 0; i < nwords * 4; i++) begin
      send_byte(b);
      cs = cs ^ b;
      b  = b + step;
    end
    send_byte(cs ^ csum_flip);
  endtask

  task automatic wait_status(input int max_cycles, input string name);
    int n;
    n = 0;
    while (!(bus.oLoadDone || bus.oError) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_in_time"}, 64'(bus.oLoadDone || bus.oError), 64'd1);
  endtask

  task automatic check_status(input string name, input logic hold, input logic done,
                              input logic err, input logic [2:0] code, input logic [15:0] wc);
    check({name, "_hold"}, 64'(bus.oCpuHold), 64'(hold));
    check({name, "_done"}, 64'(bus.oLoadDone), 64'(done));
    check({name, "_err"}, 64'(bus.oError), 64'(err));
    check({name, "_code"}, 64'(bus.oErrorCode), 64'(code));
    check({name, "_wc"}, 64'(bus.oWordCount), 64'(wc));
  endtask

  task automatic check_all_zero(input string name);
    check_status(name, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    check({name, "_we"}, 64'(bus.oWriteEnable), 64'd0);
    check({name, "_addr"}, 64'(bus.oWriteAddress), 64'd0);
    check({name, "_data"}, 64'(bus.oWriteData), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    bus.iStartLoad = 1'b0;
    bus.iRxValid   = 1'b0;
    bus.iRxByte    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);
    check_status("idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    send_byte(8'h5A);
    check_status("idle_ignores_rx", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

    // Two-word image into region 0, then end marker.
    start_load();
    check_status("started", 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    push(0, 0, 32'h44332211);
    push(0, 1, 32'h88776655);
    send_header(8'h00, 16'd2);
    send_data(2, 8'h11, 8'h11, 8'h00);
    send_byte(8'h5A);
    check_status("frame1", 1'b0, 1'b1, 1'b0, 3'd0, 16'd2);

    // No frames yet: idle timeout keeps waiting; after two frames it ends the session.
    start_load();
    idle(2 * TO + 3);
    check_status("idle_no_frame", 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    push(0, 0, 32'h04030201);
    send_header(8'h00, 16'd1);
    send_data(1, 8'h01, 8'h01, 8'h00);
    push(1, 0, 32'hDDCCBBAA);
    send_header(8'h01, 16'd1);
    send_data(1, 8'hAA, 8'h11, 8'h00);
    idle(TO - 5);
    check_status("before_timeout", 1'b1, 1'b0, 1'b0, 3'd0, 16'd2);
    wait_status(TO, "timeout_done");
    check_status("timeout_done", 1'b0, 1'b1, 1'b0, 3'd0, 16'd2);

    // Region out of range.
    start_load();
    send_byte(8'hA5);
    send_byte(8'h02);
    check_status("bad_region", 1'b1, 1'b0, 1'b1, 3'd1, 16'd0);

    // Length boundaries: zero and one past the region size.
    start_load();
    send_header(8'h00, 16'd0);
    check_status("len_zero", 1'b1, 1'b0, 1'b1, 3'd2, 16'd0);
    start_load();
    send_header(8'h01, 16'd17);
    check_status("len_over", 1'b1, 1'b0, 1'b1, 3'd2, 16'd0);

    // Bad header byte.
    start_load();
    send_byte(8'h33);
    check_status("bad_header", 1'b1, 1'b0, 1'b1, 3'd5, 16'd0);

    // Checksum mismatch: the word already written stays counted.
    start_load();
    push(1, 0, 32'h04030201);
    send_header(8'h01, 16'd1);
    send_data(1, 8'h01, 8'h01, 8'h55);
    check_status("bad_csum", 1'b1, 1'b0, 1'b1, 3'd3, 16'd1);
    send_byte(8'h5A);
    check_status("error_ignores_rx", 1'b1, 1'b0, 1'b1, 3'd3, 16'd1);
    start_load();
    check_status("restart", 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    send_byte(8'h5A);
    check_status("restart_wait_hdr", 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);

    // Stall inside a data word.
    start_load();
    send_header(8'h01, 16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_status(TO + 5, "data_timeout");
    check_status("data_timeout", 1'b1, 1'b0, 1'b1, 3'd4, 16'd0);

    // Start and a byte in the same cycle: the byte is dropped.
    bus.iStartLoad = 1'b1;
    bus.iRxValid   = 1'b1;
    bus.iRxByte    = 8'h5A;
    @(posedge clk);
    #1;
    bus.iStartLoad = 1'b0;
    bus.iRxValid   = 1'b0;
    check_status("start_drop", 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    send_byte(8'h5A);
    check_status("start_drop_hdr", 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);

    // Asynchronous reset in the middle of a word.
    start_load();
    send_header(8'h00, 16'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-size frame into region 1.
    start_load();
    b = 8'h10;
    for (int i = 0; i < 16; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        w = w | (32'(b) << (8 * j));
        b = b + 8'h01;
      end
      push(1, i, w);
    end
    send_header(8'h01, 16'd16);
    send_data(16, 8'h10, 8'h01, 8'h00);
    send_byte(8'h5A);
    check_status("full_frame", 1'b0, 1'b1, 1'b0, 3'd0, 16'd16);
    check("full_frame_last_addr", 64'(bus.oWriteAddress), 64'd15);

    idle(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
